stream_out_buf: RTL and testbench

- Output-side buffer directly downstream of the stream controller. Accepts the 32-beat result stream (valid/last/data) and presents it as an AXI4-Stream master (M_AXIS).
- Absorbs M_AXIS_TREADY backpressure through a small FIFO, so the core array stalls only when the buffer is nearly full.
- Checks packet framing and counts completed packets.

---
 rtl/stream_out_buf.sv | 167 ++++++++++++++++
 tb/tb_stream_out_buf.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_out_buf.sv
// stream_out_buf: output buffer between the stream controller and an AXI4-Stream master.
// A small FIFO absorbs M_AXIS backpressure. Packet framing is checked and completed
// output packets are counted.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_last/in_data    upstream beat (stream controller dst_*)
//   in_ready                    registered ready back to the stream controller
//   m_axis_t{valid,data,last}   AXIS master outputs, registered copy of the FIFO head
//   m_axis_tready               AXIS ready
//   err_clr                     synchronous clear of the sticky error flags
//   err_len, err_ovf            sticky packet-length and write-while-full errors
//   pkt_done                    pulse in the cycle after a TLAST beat handshakes
//   pkt_cnt                     completed output packets, wraps
module stream_out_buf #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned BEATS = 32,
    parameter int unsigned PCW   = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    input  logic           in_last,
    input  logic [DW-1:0]  in_data,
    output logic           in_ready,
    output logic           m_axis_tvalid,
    output logic [DW-1:0]  m_axis_tdata,
    output logic           m_axis_tlast,
    input  logic           m_axis_tready,
    input  logic           err_clr,
    output logic           err_len,
    output logic           err_ovf,
    output logic           pkt_done,
    output logic [PCW-1:0] pkt_cnt
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned BCW = $clog2(BEATS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    logic [DW:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_rem;
    logic [CW-1:0]  count_next;
    logic [BCW-1:0] beat_cnt;
    logic [BCW-1:0] beat_num;
    state_t         state;
    state_t         state_next;
    logic           wr;
    logic           rd;
    logic           wr_last;
    logic           len_err;
    logic           ovf_err;
    logic           done;
    logic [DW:0]    head_next;

    assign wr = in_valid & in_ready;
    assign rd = m_axis_tvalid & m_axis_tready;

    // Framing check, next state and next FIFO head.
    always_comb begin
        beat_num   = beat_cnt + BCW'(1);
        wr_last    = in_last;
        len_err    = 1'b0;
        state_next = state;
        done       = 1'b0;
        head_next  = '0;

        if (wr) begin
            if (in_last && (beat_num != BCW'(BEATS))) begin
                len_err = 1'b1;
            end
            // Missing last: terminate the packet ourselves so downstream never hangs.
            if (!in_last && (beat_num == BCW'(BEATS))) begin
                len_err = 1'b1;
                wr_last = 1'b1;
            end
            state_next = wr_last ? FLUSH : RECV;
        end

        // The only stored last bit while flushing is the packet terminator.
        if ((state == FLUSH) && rd && m_axis_tlast) begin
            done       = 1'b1;
            state_next = IDLE;
        end

        ovf_err    = in_valid & ~in_ready & (count == CW'(DEPTH));
        count_rem  = count - CW'(rd);
        count_next = count_rem + CW'(wr);

        // Entry being written becomes the head when nothing older remains.
        if (count_next != '0) begin
            if (count_rem == '0) begin
                head_next = {wr_last, in_data};
            end else begin
                head_next = mem[rd_ptr + AW'(rd)];
            end
        end
    end

    // FIFO storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= {wr_last, in_data};
        end
    end

    // Control state, pointers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            beat_cnt      <= '0;
            state         <= IDLE;
            in_ready      <= 1'b1;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            err_len       <= 1'b0;
            err_ovf       <= 1'b0;
            pkt_done      <= 1'b0;
            pkt_cnt       <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            state <= state_next;

            if (done) begin
                beat_cnt <= '0;
            end else if (wr) begin
                beat_cnt <= beat_num;
            end

            // Two free entries cover the controller's ready-to-valid lag.
            in_ready <= (count_next <= CW'(DEPTH - 2)) && (state_next != FLUSH);

            m_axis_tvalid <= (count_next != '0);
            m_axis_tdata  <= head_next[DW-1:0];
            m_axis_tlast  <= head_next[DW];

            pkt_done <= done;
            if (done) begin
                pkt_cnt <= pkt_cnt + PCW'(1);
            end

            // Sticky flags: a new event beats a coincident clear.
            err_len <= len_err | (err_len & ~err_clr);
            err_ovf <= ovf_err | (err_ovf & ~err_clr);
        end
    end

endmodule

// File: tb/tb_stream_out_buf.sv
// Testbench for stream_out_buf: directed table, hand sequences and random traffic
// checked against a queue-based reference model.
module tb_stream_out_buf;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned BEATS = 32;
    localparam int unsigned PCW   = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_last = 1'b0;
    logic [DW-1:0]  in_data = '0;
    logic           in_ready;
    logic           m_axis_tvalid;
    logic [DW-1:0]  m_axis_tdata;
    logic           m_axis_tlast;
    logic           m_axis_tready = 1'b0;
    logic           err_clr = 1'b0;
    logic           err_len;
    logic           err_ovf;
    logic           pkt_done;
    logic [PCW-1:0] pkt_cnt;

    stream_out_buf #(.DW(DW), .DEPTH(DEPTH), .BEATS(BEATS), .PCW(PCW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_last(in_last), .in_data(in_data), .in_ready(in_ready),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .err_clr(err_clr), .err_len(err_len), .err_ovf(err_ovf),
        .pkt_done(pkt_done), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic           in_ready;
        logic           tvalid;
        logic [DW-1:0]  tdata;
        logic           tlast;
        logic           pkt_done;
        logic [PCW-1:0] pkt_cnt;
        logic           err_len;
        logic           err_ovf;
    } obs_t;

    typedef struct packed {
        logic          iv;
        logic          il;
        logic [DW-1:0] id;
        logic          tr;
        logic          clr;
        obs_t          exp;
    } vec_t;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } ent_t;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: FIFO contents as a queue plus packet bookkeeping.
    ent_t           q[$];
    ent_t           outq[$];
    int             bc;
    bit             flush;
    bit             m_ready;
    bit             m_done;
    bit             m_elen;
    bit             m_eovf;
    logic [PCW-1:0] m_cnt;

    function automatic obs_t mk(bit rdy, bit v, logic [DW-1:0] d, bit l, bit dn,
                                int cnt, bit el);
        obs_t o;
        o.in_ready = rdy; o.tvalid = v; o.tdata = d; o.tlast = l;
        o.pkt_done = dn; o.pkt_cnt = PCW'(cnt); o.err_len = el; o.err_ovf = 1'b0;
        return o;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o = '0;
        o.in_ready = m_ready;
        o.tvalid   = (q.size() != 0);
        if (q.size() != 0) begin
            o.tdata = q[0].data;
            o.tlast = q[0].last;
        end
        o.pkt_done = m_done;
        o.pkt_cnt  = m_cnt;
        o.err_len  = m_elen;
        o.err_ovf  = m_eovf;
        return o;
    endfunction

    task automatic model_reset();
        q.delete();
        bc = 0; flush = 0; m_ready = 1; m_done = 0; m_elen = 0; m_eovf = 0; m_cnt = '0;
    endtask

    task automatic model_step(bit iv, bit il, logic [DW-1:0] id, bit tr, bit clr);
        bit   wr, rd, done, le, oe;
        ent_t e;
        wr   = iv && m_ready;
        rd   = (q.size() != 0) && tr;
        oe   = iv && !m_ready && (q.size() == int'(DEPTH));
        done = rd && flush && q[0].last;
        le   = 0;
        if (rd) void'(q.pop_front());
        if (wr) begin
            bc++;
            e.data = id;
            e.last = il;
            if (il && bc != int'(BEATS)) le = 1;
            if (!il && bc == int'(BEATS)) begin
                le = 1;
                e.last = 1;
            end
            q.push_back(e);
            if (e.last) flush = 1;
        end
        if (done) begin
            flush = 0;
            bc = 0;
            m_cnt = m_cnt + PCW'(1);
        end
        m_done  = done;
        m_elen  = le | (m_elen & !clr);
        m_eovf  = oe | (m_eovf & !clr);
        m_ready = (q.size() <= int'(DEPTH) - 2) && !flush;
    endtask

    // Drive one cycle of inputs, advance the model, sample just after the edge.
    task automatic apply(bit iv, bit il, logic [DW-1:0] id, bit tr, bit clr);
        ent_t e;
        @(negedge clk);
        in_valid = iv; in_last = il; in_data = id; m_axis_tready = tr; err_clr = clr;
        if (m_axis_tvalid && tr) begin
            e.data = m_axis_tdata;
            e.last = m_axis_tlast;
            outq.push_back(e);
        end
        model_step(iv, il, id, tr, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, obs_t exp_in);
        obs_t got, exp;
        exp = exp_in;
        got.in_ready = in_ready; got.tvalid = m_axis_tvalid; got.tdata = m_axis_tdata;
        got.tlast = m_axis_tlast; got.pkt_done = pkt_done; got.pkt_cnt = pkt_cnt;
        got.err_len = err_len; got.err_ovf = err_ovf;
        // Head data is only meaningful while tvalid is expected.
        if (!exp.tvalid) begin
            got.tdata = '0; got.tlast = 1'b0;
            exp.tdata = '0; exp.tlast = 1'b0;
        end
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got rdy=%b v=%b d=%h l=%b done=%b cnt=%0d elen=%b eovf=%b, expected rdy=%b v=%b d=%h l=%b done=%b cnt=%0d elen=%b eovf=%b",
                     name, got.in_ready, got.tvalid, got.tdata, got.tlast, got.pkt_done,
                     got.pkt_cnt, got.err_len, got.err_ovf, exp.in_ready, exp.tvalid,
                     exp.tdata, exp.tlast, exp.pkt_done, exp.pkt_cnt, exp.err_len, exp.err_ovf);
        end
    endtask

    task automatic check_val(string name, int got, int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Output stream must be base..base+n-1 with tlast only on index last_idx.
    task automatic check_outq(string name, int n, int last_idx, int base);
        check_val({name, " beats"}, outq.size(), n);
        for (int i = 0; i < n && i < outq.size(); i++) begin
            check_val($sformatf("%s data[%0d]", name, i), int'(outq[i].data), base + i);
            check_val($sformatf("%s last[%0d]", name, i), int'(outq[i].last),
                      (i == last_idx) ? 1 : 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 0; in_last = 0; in_data = '0; m_axis_tready = 0; err_clr = 0;
        #1;
        rst_n = 0;
        #1;
        model_reset();
        check("reset", mk(1, 0, '0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1;
        outq.delete();
    endtask

    // Send n beats (data base+i, last on index last_at or never), with tready low
    // during cycles slo..shi; optionally keep going until the FIFO has drained.
    task automatic send(string tag, int n, int last_at, int slo, int shi, int base,
                        bit drain);
        int i   = 0;
        int cyc = 0;
        bit tr, acc;
        while ((i < n || (drain && q.size() != 0)) && cyc < 2000) begin
            tr  = !(cyc >= slo && cyc <= shi);
            acc = (i < n) && m_ready;
            if (i < n) apply(1, i == last_at, DW'(base + i), tr, 0);
            else       apply(0, 0, '0, tr, 0);
            check($sformatf("%s c%0d", tag, cyc), model_obs());
            if (acc) i++;
            cyc++;
        end
        if (cyc >= 2000) begin
            n_vec++;
            n_err++;
            $display("FAIL %s timeout: got %0d beats expected %0d", tag, i, n);
        end
    endtask

    vec_t tbl[13];

    initial begin
        int sb, plen, r;
        bit iv, il, tr, clr, acc, stall;
        logic [DW-1:0] dseq;

        // Short packets, backpressure to count 3, err_clr vs new-error priority.
        tbl[0]  = '{1, 0, 32'hA0, 1, 0, mk(1, 1, 32'hA0, 0, 0, 0, 0)};
        tbl[1]  = '{1, 0, 32'hA1, 0, 0, mk(1, 1, 32'hA0, 0, 0, 0, 0)};
        tbl[2]  = '{1, 0, 32'hA2, 0, 0, mk(0, 1, 32'hA0, 0, 0, 0, 0)};
        tbl[3]  = '{1, 0, 32'hEE, 0, 0, mk(0, 1, 32'hA0, 0, 0, 0, 0)};
        tbl[4]  = '{0, 0, 32'h00, 1, 0, mk(1, 1, 32'hA1, 0, 0, 0, 0)};
        tbl[5]  = '{1, 1, 32'hA3, 1, 0, mk(0, 1, 32'hA2, 0, 0, 0, 1)};
        tbl[6]  = '{1, 0, 32'hEE, 1, 0, mk(0, 1, 32'hA3, 1, 0, 0, 1)};
        tbl[7]  = '{0, 0, 32'h00, 0, 0, mk(0, 1, 32'hA3, 1, 0, 0, 1)};
        tbl[8]  = '{0, 0, 32'h00, 1, 1, mk(1, 0, 32'h00, 0, 1, 1, 0)};
        tbl[9]  = '{0, 0, 32'h00, 1, 0, mk(1, 0, 32'h00, 0, 0, 1, 0)};
        tbl[10] = '{1, 1, 32'hB0, 0, 1, mk(0, 1, 32'hB0, 1, 0, 1, 1)};
        tbl[11] = '{0, 0, 32'h00, 1, 0, mk(1, 0, 32'h00, 0, 1, 2, 1)};
        tbl[12] = '{0, 0, 32'h00, 1, 1, mk(1, 0, 32'h00, 0, 0, 2, 0)};

        do_reset();
        for (int i = 0; i < 13; i++) begin
            apply(tbl[i].iv, tbl[i].il, tbl[i].id, tbl[i].tr, tbl[i].clr);
            check($sformatf("tbl[%0d]", i), tbl[i].exp);
        end

        // Nominal packet, no backpressure.
        do_reset();
        send("nominal", 32, 31, -1, -1, 0, 1);
        check_outq("nominal", 32, 31, 0);
        check_val("nominal pkt_cnt", int'(pkt_cnt), 1);
        check_val("nominal err_len", int'(err_len), 0);

        // Backpressure during cycles 5..20.
        do_reset();
        send("bp", 32, 31, 5, 20, 100, 1);
        check_outq("bp", 32, 31, 100);
        check_val("bp err_ovf", int'(err_ovf), 0);
        check_val("bp pkt_cnt", int'(pkt_cnt), 1);

        // Short packet then error clear.
        do_reset();
        send("short", 10, 9, -1, -1, 200, 1);
        check_outq("short", 10, 9, 200);
        check_val("short err_len", int'(err_len), 1);
        apply(0, 0, '0, 1, 1);
        check("short clr", model_obs());
        check_val("short err_len clr", int'(err_len), 0);

        // Missing last: beat 32 forced last, beat 33 held off until completion.
        do_reset();
        send("nolast", 33, -1, -1, -1, 300, 1);
        check_outq("nolast", 33, 31, 300);
        check_val("nolast err_len", int'(err_len), 1);
        check_val("nolast pkt_cnt", int'(pkt_cnt), 1);

        // Reset mid-packet with beats still buffered.
        do_reset();
        send("midrst", 12, -1, 0, 1000, 400, 0);
        do_reset();
        send("afterrst", 32, 31, -1, -1, 500, 1);
        check_outq("afterrst", 32, 31, 500);
        check_val("afterrst pkt_cnt", int'(pkt_cnt), 1);
        check_val("afterrst err_len", int'(err_len), 0);

        // Random traffic: mixed lengths, missing lasts, bursty backpressure.
        do_reset();
        sb = 0; plen = 32; dseq = '0; stall = 0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 15) == 0) stall = !stall;
            iv  = ($urandom_range(0, 3) != 0);
            il  = (sb + 1 == plen);
            tr  = stall ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 49) == 0);
            acc = iv && m_ready;
            apply(iv, il, dseq, tr, clr);
            check($sformatf("rand c%0d", c), model_obs());
            if (acc) begin
                dseq = dseq + DW'(1);
                sb++;
                if (il || sb == int'(BEATS)) begin
                    sb = 0;
                    r  = int'($urandom_range(0, 9));
                    plen = (r < 6) ? 32 : (r < 8) ? int'($urandom_range(1, 31)) : 0;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
